// File: rtl/cast_route_fork.sv
`default_nettype none
// ============================================================================
//  Module      : cast_route_fork
//  Description : Per-input-port multicast route stage. Presents the stream_id
//                of a head flit to the downstream route table, latches the
//                returned candidate mask for the whole packet, and forks each
//                flit to every selected output VC. A flit is popped from the
//                input buffer only once all selected outputs have accepted it.
//  Ports       :
//     clk           clock
//     rstn          asynchronous active-low reset
//     in_valid      input buffer head flit valid
//     in_flit       input buffer head flit ([FLIT_W-1:FLIT_W-2] = type)
//     in_ready      pop strobe to the input buffer
//     rt_stream_id  registered stream_id presented to the route table
//     rt_candidate  route table result (combinational from rt_stream_id)
//     out_req       per-output-VC request for the current flit
//     out_grant     per-output-VC acceptance of out_flit this cycle
//     out_flit      flit broadcast to all requested outputs
//     route_busy    packet in progress
//     err_pulse     one-cycle protocol error pulse (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module cast_route_fork #(
   parameter int CN     = 4,
   parameter int FLIT_W = 64,
   parameter int ERR_EN = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              in_ready,
   output logic [9:0]        rt_stream_id,
   input  logic [CN-1:0]     rt_candidate,
   output logic [CN-1:0]     out_req,
   input  logic [CN-1:0]     out_grant,
   output logic [FLIT_W-1:0] out_flit,
   output logic              route_busy,
   output logic              err_pulse
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LOOKUP  = 2'd1;
   localparam logic [1:0] FORWARD = 2'd2;

   logic [1:0]    state;
   logic [CN-1:0] route_mask;
   logic [CN-1:0] pending;
   // Set while the packet's own head flit is still the buffer head, so a
   // later head-type flit can be recognised as a protocol error.
   logic          first_flit;

   logic [1:0]    flit_type;
   logic          is_head;
   logic          is_tail;
   logic          done;
   logic          ready_raw;
   logic [CN-1:0] req_raw;
   logic          err_next;

   assign flit_type = in_flit[FLIT_W-1:FLIT_W-2];
   assign is_head   = flit_type[0];   // 01 or 11
   assign is_tail   = flit_type[1];   // 10 or 11

   // All still-pending outputs either granted now or earlier. A zero mask
   // makes this true on any valid flit, which discards the packet.
   assign done = in_valid && ((pending & ~out_grant) == '0);

   always_comb begin
      ready_raw = 1'b0;
      req_raw   = '0;
      err_next  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && !is_head) begin
               ready_raw = 1'b1;   // drop stray body/tail
               err_next  = 1'b1;
            end
         end
         FORWARD: begin
            req_raw   = pending & {CN{in_valid}};
            ready_raw = done;
            // Flag a mid-packet head once, when it is consumed.
            err_next  = done && !first_flit && (flit_type == 2'b01);
         end
         default: ;
      endcase
   end

   // Pop and requests are forced low while reset is held, independent of
   // whatever the buffer is presenting.
   assign in_ready   = ready_raw & rstn;
   assign out_req    = req_raw & {CN{rstn}};
   assign out_flit   = in_flit;
   assign route_busy = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         route_mask   <= '0;
         pending      <= '0;
         rt_stream_id <= '0;
         first_flit   <= 1'b0;
         err_pulse    <= 1'b0;
      end else begin
         err_pulse <= (ERR_EN != 0) && err_next;
         case (state)
            IDLE: begin
               if (in_valid && is_head) begin
                  rt_stream_id <= in_flit[9:0];
                  state        <= LOOKUP;
               end
            end
            LOOKUP: begin
               route_mask <= rt_candidate;
               pending    <= rt_candidate;
               first_flit <= 1'b1;
               state      <= FORWARD;
            end
            FORWARD: begin
               if (done) begin
                  pending    <= route_mask;
                  first_flit <= 1'b0;
                  if (is_tail) begin
                     state <= IDLE;
                  end
               end else if (in_valid) begin
                  pending <= pending & ~out_grant;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cast_route_fork.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cast_route_fork
//  Description : Directed self-checking bench for cast_route_fork with a small
//                route table model (5->0010, 7->1011, 9->0100, else 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cast_route_fork;

   localparam int CN     = 4;
   localparam int FLIT_W = 64;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              in_valid = 1'b0;
   logic [FLIT_W-1:0] in_flit = '0;
   logic              in_ready;
   logic [9:0]        rt_stream_id;
   logic [CN-1:0]     rt_candidate;
   logic [CN-1:0]     out_req;
   logic [CN-1:0]     out_grant = '0;
   logic [FLIT_W-1:0] out_flit;
   logic              route_busy;
   logic              err_pulse;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always_comb begin
      case (rt_stream_id)
         10'd5:   rt_candidate = 4'b0010;
         10'd7:   rt_candidate = 4'b1011;
         10'd9:   rt_candidate = 4'b0100;
         default: rt_candidate = 4'b0000;
      endcase
   end

   cast_route_fork #(.CN(CN), .FLIT_W(FLIT_W), .ERR_EN(1)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_flit(in_flit),
      .in_ready(in_ready), .rt_stream_id(rt_stream_id), .rt_candidate(rt_candidate),
      .out_req(out_req), .out_grant(out_grant), .out_flit(out_flit),
      .route_busy(route_busy), .err_pulse(err_pulse)
   );

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [9:0] lo);
      return {t, 52'h5_A5A5_A5A5_A5A5, lo};
   endfunction

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Apply inputs for this cycle and let combinational outputs settle.
   task automatic drive(input logic v, input logic [1:0] t, input logic [9:0] lo,
                        input logic [CN-1:0] g);
      in_valid  = v;
      in_flit   = mk(t, lo);
      out_grant = g;
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive(1'b1, 2'b00, 10'd1, 4'b0000);
      chk("reset in_ready", in_ready, 0);
      chk("reset out_req", out_req, 0);
      chk("reset busy", route_busy, 0);
      chk("reset sid", rt_stream_id, 0);
      chk("reset err", err_pulse, 0);
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      cyc();
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_unicast();
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      chk("t1 c0 in_ready", in_ready, 0);
      chk("t1 c0 out_req", out_req, 0);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      chk("t1 lookup busy", route_busy, 1);
      chk("t1 lookup sid", rt_stream_id, 5);
      chk("t1 lookup out_req", out_req, 0);
      chk("t1 lookup in_ready", in_ready, 0);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0010);
      chk("t1 head out_req", out_req, 4'b0010);
      chk("t1 head pop", in_ready, 1);
      chk("t1 out_flit", out_flit, mk(2'b01, 10'd5));
      cyc();
      drive(1'b1, 2'b00, 10'd100, 4'b0010);
      chk("t1 body out_req", out_req, 4'b0010);
      chk("t1 body pop", in_ready, 1);
      cyc();
      drive(1'b1, 2'b10, 10'd101, 4'b0010);
      chk("t1 tail pop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t1 idle busy", route_busy, 0);
      chk("t1 no err", err_pulse, 0);
      cyc();
   endtask

   task automatic test_multicast_partial();
      drive(1'b1, 2'b01, 10'd7, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd7, 4'b0000);
      cyc();
      // Bit 2 is outside out_req and must be ignored.
      drive(1'b1, 2'b01, 10'd7, 4'b0101);
      chk("t2 req1", out_req, 4'b1011);
      chk("t2 pop1", in_ready, 0);
      cyc();
      drive(1'b1, 2'b01, 10'd7, 4'b1000);
      chk("t2 req2", out_req, 4'b1010);
      chk("t2 pop2", in_ready, 0);
      cyc();
      drive(1'b0, 2'b01, 10'd7, 4'b0000);
      chk("t2 invalid req", out_req, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd7, 4'b0010);
      chk("t2 req3", out_req, 4'b0010);
      chk("t2 pop3", in_ready, 1);
      cyc();
      drive(1'b1, 2'b10, 10'd8, 4'b1011);
      chk("t2 next flit req", out_req, 4'b1011);
      chk("t2 tail pop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t2 idle busy", route_busy, 0);
      cyc();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'b11, 10'd9, 4'b0000);
      cyc();
      drive(1'b1, 2'b11, 10'd9, 4'b0000);
      cyc();
      drive(1'b1, 2'b11, 10'd9, 4'b0100);
      chk("t3 req", out_req, 4'b0100);
      chk("t3 pop", in_ready, 1);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      chk("t3 idle busy", route_busy, 0);
      chk("t3 head not popped", in_ready, 0);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      chk("t3 b2b sid", rt_stream_id, 5);
      chk("t3 b2b busy", route_busy, 1);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0010);
      chk("t3 b2b req", out_req, 4'b0010);
      cyc();
      drive(1'b1, 2'b10, 10'd6, 4'b0010);
      chk("t3 b2b tail pop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      cyc();
   endtask

   task automatic test_zero_route();
      logic [1:0] types [4];
      types[0] = 2'b01; types[1] = 2'b00; types[2] = 2'b00; types[3] = 2'b10;
      drive(1'b1, 2'b01, 10'h3FF, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'h3FF, 4'b0000);
      cyc();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, types[i], 10'h3FF, 4'b0000);
         chk($sformatf("t4 req %0d", i), out_req, 4'b0000);
         chk($sformatf("t4 pop %0d", i), in_ready, 1);
         chk($sformatf("t4 err %0d", i), err_pulse, 0);
         cyc();
      end
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t4 idle busy", route_busy, 0);
      chk("t4 final err", err_pulse, 0);
      cyc();
   endtask

   task automatic test_protocol_errors();
      drive(1'b1, 2'b00, 10'd3, 4'b0000);
      chk("t5a drop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t5a err", err_pulse, 1);
      chk("t5a stays idle", route_busy, 0);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t5a err one cycle", err_pulse, 0);
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd5, 4'b0010);
      chk("t5b head pop", in_ready, 1);
      cyc();
      drive(1'b1, 2'b01, 10'd9, 4'b0010);
      chk("t5b stray head req", out_req, 4'b0010);
      chk("t5b stray head pop", in_ready, 1);
      chk("t5b err before", err_pulse, 0);
      cyc();
      drive(1'b1, 2'b10, 10'd6, 4'b0010);
      chk("t5b err", err_pulse, 1);
      chk("t5b sid kept", rt_stream_id, 5);
      chk("t5b tail pop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t5b err one cycle", err_pulse, 0);
      chk("t5b idle", route_busy, 0);
      cyc();
   endtask

   task automatic test_reset_mid_packet();
      drive(1'b1, 2'b01, 10'd9, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd9, 4'b0000);
      cyc();
      drive(1'b1, 2'b01, 10'd9, 4'b0000);
      chk("t6 pending req", out_req, 4'b0100);
      #1;
      rstn = 1'b0;
      #1;
      chk("t6 async req", out_req, 4'b0000);
      chk("t6 async pop", in_ready, 0);
      chk("t6 async busy", route_busy, 0);
      cyc();
      cyc();
      rstn = 1'b1;
      drive(1'b1, 2'b11, 10'd5, 4'b0000);
      cyc();
      drive(1'b1, 2'b11, 10'd5, 4'b0000);
      chk("t6 relookup sid", rt_stream_id, 5);
      cyc();
      drive(1'b1, 2'b11, 10'd5, 4'b0010);
      chk("t6 route req", out_req, 4'b0010);
      chk("t6 route pop", in_ready, 1);
      cyc();
      drive(1'b0, 2'b00, 10'd0, 4'b0000);
      chk("t6 idle", route_busy, 0);
      cyc();
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_multicast_partial();
      test_back_to_back();
      test_zero_route();
      test_protocol_errors();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
